// File: rtl/prime_collector.sv
// Drives a handshaked prime generator and queues strictly increasing results in a FIFO.
// Any generator fault or out-of-order result latches err and parks the FSM until reset.
module prime_collector #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             gen_go,
    input  logic             gen_ready,
    input  logic             gen_error,
    input  logic [WIDTH-1:0] gen_res,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      level,
    output logic             err,
    output logic [31:0]      total
);

    typedef enum logic [2:0] {
        IDLE,
        GO,
        WAIT_LOW,
        WAIT_HIGH,
        HALT
    } state_t;

    state_t           state_q;
    logic             gen_go_q;
    logic             err_q;
    logic [31:0]      total_q;
    logic [WIDTH-1:0] prev_q;
    logic             have_prev_q;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW:0]      level_q, level_d;
    logic [WIDTH-1:0] dout_q, dout_d;

    logic capture;
    logic res_ok;
    logic do_write;
    logic do_pop;

    assign capture  = (state_q == WAIT_HIGH) && gen_ready;
    assign res_ok   = !gen_error && (!have_prev_q || (gen_res > prev_q));
    assign do_write = capture && res_ok;
    assign do_pop   = pop && (level_q != '0);

    // A write landing on the slot that becomes the head must bypass the array.
    always_comb begin
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        level_d  = level_q;
        if (do_write && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (!do_write && do_pop) begin
            level_d = level_q - 1'b1;
        end
        dout_d = mem_q[rd_ptr_d];
        if (do_write && (wr_ptr_q == rd_ptr_d)) begin
            dout_d = gen_res;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            gen_go_q    <= 1'b0;
            err_q       <= 1'b0;
            total_q     <= '0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en && !err_q && (level_q < (AW+1)'(DEPTH))) begin
                        state_q  <= GO;
                        gen_go_q <= 1'b1;
                    end
                end
                GO: begin
                    gen_go_q <= 1'b0;
                    state_q  <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!gen_ready) begin
                        state_q <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (gen_ready) begin
                        if (res_ok) begin
                            state_q     <= IDLE;
                            prev_q      <= gen_res;
                            have_prev_q <= 1'b1;
                            total_q     <= total_q + 32'd1;
                        end else begin
                            state_q <= HALT;
                            err_q   <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q  <= IDLE;
                    gen_go_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            dout_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            dout_q   <= dout_d;
            if (do_write) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= gen_res;
        end
    end

    assign gen_go = gen_go_q;
    assign err    = err_q;
    assign total  = total_q;
    assign level  = level_q;
    assign dout   = dout_q;
    assign empty  = (level_q == '0);
    assign full   = (level_q == (AW+1)'(DEPTH));

endmodule
